irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Collects the microcontroller's interrupt sources (int_ext1, int_ext2, tim1_cmp, tim2_cmp) and forwards them to the core one at a time.
//  Holds the per-source state: pending, enable and trigger mode.
//  Picks one source by fixed priority and drives a single request/ack/done handshake into the core.
//  Sits between the peripheral IRQ lines and the core; software reaches it through a small config register port.
// PARAMETERS
//  NUM_SOURCES  4                        number of IRQ inputs; bit 0 = int_ext1, 1 = int_ext2, 2 = tim1_cmp, 3 = tim2_cmp
//  ID_W         $clog2(NUM_SOURCES)      width of irq_id
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high reset
//  src_in      in   NUM_SOURCES  raw interrupt lines
//  cfg_we      in   1            config write strobe
//  cfg_addr    in   2            0 = ENABLE, 1 = PENDING, 2 = MODE, 3 = STATUS (read-only)
//  cfg_wdata   in   NUM_SOURCES  write data
//  cfg_rdata   out  NUM_SOURCES  combinational read of the register at cfg_addr
//  irq_req     out  1            interrupt request to the core (registered)
//  irq_id      out  ID_W         index of the presented source; valid while irq_req = 1
//  irq_ack     in   1            core has taken the request (1-cycle pulse)
//  irq_done    in   1            core has finished the handler (mret, 1-cycle pulse)
// BEHAVIOUR
//  Reset values
//   - ENABLE = 0, PENDING = 0, MODE = 0 (all edge-triggered).
//   - State = IDLE; irq_req = 0; irq_id = 0; edge history = 0.
//   - Reset asserted mid-handshake discards everything; no request survives it.
//  Sampling (edge mode)
//   - src_s is the sampled line; src_prev is src_s from the previous cycle.
//   - src_s & ~src_prev in cycle t sets PENDING[i] at the clock edge ending cycle t.
//  Sampling (level mode)
//   - PENDING[i] is reloaded every cycle with src_s[i].
//   - Ack and software writes have no effect on it.
//  PENDING writes
//   - Software writes 1 to clear; writing 0 leaves the bit unchanged.
//   - A hardware set in the same cycle as a clear (software or ack) wins: the bit stays 1.
//  Arbitration
//   - active = PENDING & ENABLE.
//   - Lowest set index wins. It is latched into irq_id in IDLE.
//  FSM
//   - IDLE -> REQ when active != 0. irq_id is latched and irq_req = 1 from the next cycle.
//   - REQ, irq_ack = 1 -> SERVICE. Clear PENDING[irq_id] if that source is edge-mode. irq_req = 0 next cycle.
//   - REQ, ENABLE[irq_id] cleared and no ack -> IDLE (withdraw). irq_req = 0 next cycle.
//     If ack arrives in the same cycle as the disable, the ack wins.
//   - SERVICE, irq_done = 1 -> IDLE. Arbitration resumes the cycle after.
//   - No nesting: new pendings accumulate during SERVICE.
//   - irq_ack outside REQ and irq_done outside SERVICE are ignored.
//  Latency, no sync, edge mode
//   - Edge seen in cycle t -> PENDING visible at t+1 -> irq_req = 1 at t+2.
//  STATUS readback
//   - {irq_req, state != IDLE} in bits [1:0]; upper bits read 0.
//  Arithmetic
//   - irq_id never exceeds NUM_SOURCES-1.
//   - Unused cfg_wdata bits are ignored.
// CONFIGURATION
//  IRQ_ARB_SYNC_EN defined
//   - src_in passes through a 2-flop synchronizer before sampling.
//   - Every latency above grows by 2 cycles: the edge-mode figure becomes irq_req at t+4.
//   - Synchronizer flops reset to 0.
//  IRQ_ARB_SYNC_EN undefined
//   - src_in is used directly as src_s. All sources must be synchronous to clk.
// STRUCTURE
//  Package irq_pkg
//   - state enum {IDLE, REQ, SERVICE}.
//   - Register address constants REG_ENABLE = 0, REG_PENDING = 1, REG_MODE = 2, REG_STATUS = 3.
//   - NUM_SOURCES default.
//  Sub-module irq_edge_detect
//   - One instance per source: optional sync, prev flop, rise and level outputs.
//   - FSM, register file and priority encoder stay in irq_arbiter.
// TESTING
//  1. ENABLE = 4'b1111; pulse src_in[2] at t
//     -> irq_req = 1, irq_id = 2 at t+2; ack -> irq_req = 0 and PENDING = 0 next cycle; done -> IDLE.
//  2. Sources 1 and 3 rise in the same cycle
//     -> irq_id = 1 first; after ack+done, irq_id = 3 is presented 2 cycles later.
//  3. src_in[0] rises in the ack cycle of source 0 -> PENDING[0] stays 1 and is re-requested after done.
//  4. ENABLE = 0; source 1 edge -> PENDING = 4'b0010, no irq_req
//     -> write ENABLE = 4'b0010 -> irq_req = 1 two cycles later.
//  5. In REQ, write ENABLE = 0 with no ack -> irq_req drops next cycle, PENDING kept, state IDLE.
//  6. MODE[3] = 1; hold src_in[3] high through ack+done -> re-request;
//     assert reset while in SERVICE -> irq_req = 0, registers = 0.
//  Run all scenarios with IRQ_ARB_SYNC_EN both defined (latency +2) and undefined.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared definitions for the interrupt arbiter: FSM state
//                encoding, config register addresses and the default
//                number of interrupt sources.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Default source count: bit 0 = int_ext1, 1 = int_ext2,
    // 2 = tim1_cmp, 3 = tim2_cmp
    localparam int NUM_SOURCES_DEFAULT = 4;

    // Config register map
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : irq_edge_detect
//  Description : Per-source front end. Optionally synchronises the raw line,
//                keeps one cycle of history and reports the rising edge and
//                the sampled level of the line.
//  Config      : IRQ_ARB_SYNC_EN - when defined, src_i passes through a
//                2-flop synchronizer (reset to 0) before sampling.
//  Ports       : clk      in   system clock
//                reset    in   synchronous active-high reset
//                src_i    in   raw interrupt line
//                rise_o   out  sampled line rose this cycle
//                level_o  out  sampled line level
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    output logic rise_o,
    output logic level_o
);

    logic w_src_s;
    logic r_prev_q;

`ifdef IRQ_ARB_SYNC_EN
    logic r_sync1_q;
    logic r_sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
        end else begin
            r_sync1_q <= src_i;
            r_sync2_q <= r_sync1_q;
        end
    end

    assign w_src_s = r_sync2_q;
`else
    // Source is already synchronous to clk
    assign w_src_s = src_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q <= 1'b0;
        end else begin
            r_prev_q <= w_src_s;
        end
    end

    assign rise_o  = w_src_s & ~r_prev_q;
    assign level_o = w_src_s;

endmodule : irq_edge_detect
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : Collects the interrupt sources, holds per-source PENDING,
//                ENABLE and MODE state, selects the lowest-index active
//                source and presents it to the core through a
//                request/ack/done handshake.
//  Config      : IRQ_ARB_SYNC_EN - adds a 2-flop synchronizer on every
//                source (all latencies grow by 2 cycles).
//  Ports       : clk        in   system clock
//                reset      in   synchronous active-high reset
//                src_in     in   raw interrupt lines
//                cfg_we     in   config write strobe
//                cfg_addr   in   0 ENABLE, 1 PENDING, 2 MODE, 3 STATUS
//                cfg_wdata  in   config write data
//                cfg_rdata  out  combinational read of register at cfg_addr
//                irq_req    out  registered request to the core
//                irq_id     out  presented source index (valid with irq_req)
//                irq_ack    in   core took the request (1-cycle pulse)
//                irq_done   in   handler finished (1-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = NUM_SOURCES_DEFAULT,
    parameter int ID_W        = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] src_in,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_addr,
    input  logic [NUM_SOURCES-1:0] cfg_wdata,
    output logic [NUM_SOURCES-1:0] cfg_rdata,
    output logic                   irq_req,
    output logic [ID_W-1:0]        irq_id,
    input  logic                   irq_ack,
    input  logic                   irq_done
);

    // ------------------------------------------------------------------
    // Per-source edge/level front end
    // ------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_level;

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            irq_edge_detect u_edge (
                .clk     (clk),
                .reset   (reset),
                .src_i   (src_in[gi]),
                .rise_o  (w_rise[gi]),
                .level_o (w_level[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    irq_state_e             r_state_q, w_state_d;
    logic [ID_W-1:0]        r_id_q, w_id_d;
    logic                   r_req_q, w_req_d;
    logic [NUM_SOURCES-1:0] r_pend_q, w_pend_d;
    logic [NUM_SOURCES-1:0] r_en_q, w_en_d;
    logic [NUM_SOURCES-1:0] r_mode_q, w_mode_d;

    logic [NUM_SOURCES-1:0] w_sw_clr;
    logic [NUM_SOURCES-1:0] w_ack_clr;
    logic [NUM_SOURCES-1:0] w_active;
    logic [ID_W-1:0]        w_win_id;

    // ENABLE / MODE software writes
    always_comb begin
        w_en_d   = r_en_q;
        w_mode_d = r_mode_q;
        if (cfg_we && (cfg_addr == REG_ENABLE)) begin
            w_en_d = cfg_wdata;
        end
        if (cfg_we && (cfg_addr == REG_MODE)) begin
            w_mode_d = cfg_wdata;
        end
    end

    // PENDING: level sources follow the line; edge sources are set by a
    // rise and cleared by write-1 or by the ack of that source. Set wins
    // over clear because it is ORed in last.
    always_comb begin
        w_sw_clr  = '0;
        w_ack_clr = '0;
        if (cfg_we && (cfg_addr == REG_PENDING)) begin
            w_sw_clr = cfg_wdata;
        end
        if ((r_state_q == REQ) && irq_ack) begin
            w_ack_clr[r_id_q] = 1'b1;
        end
        w_pend_d = (r_mode_q & w_level)
                 | (~r_mode_q & (w_rise | (r_pend_q & ~(w_sw_clr | w_ack_clr))));
    end

    // Fixed priority: lowest set index wins (scan high to low, last hit sticks)
    assign w_active = r_pend_q & r_en_q;

    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM (next state)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_id_d    = r_id_q;
        case (r_state_q)
            IDLE: begin
                if (|w_active) begin
                    w_state_d = REQ;
                    w_id_d    = w_win_id;
                end
            end
            REQ: begin
                // Ack beats a simultaneous disable. The disable is taken from
                // the value being written so the request drops the cycle
                // right after the ENABLE write.
                if (irq_ack) begin
                    w_state_d = SERVICE;
                end else if (!w_en_d[r_id_q]) begin
                    w_state_d = IDLE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        w_req_d = (w_state_d == REQ);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_id_q    <= '0;
            r_req_q   <= 1'b0;
            r_pend_q  <= '0;
            r_en_q    <= '0;
            r_mode_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_id_q    <= w_id_d;
            r_req_q   <= w_req_d;
            r_pend_q  <= w_pend_d;
            r_en_q    <= w_en_d;
            r_mode_q  <= w_mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq_req = r_req_q;
    assign irq_id  = r_id_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_ENABLE:  cfg_rdata = r_en_q;
            REG_PENDING: cfg_rdata = r_pend_q;
            REG_MODE:    cfg_rdata = r_mode_q;
            REG_STATUS:  cfg_rdata[1:0] = {r_req_q, (r_state_q != IDLE)};
            default:     cfg_rdata = '0;
        endcase
    end

endmodule : irq_arbiter
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_arbiter
//  Description : Self-checking bench for irq_arbiter. A behavioural model
//                tracks the expected registers and handshake; a compare
//                process checks the DUT against it every cycle, and directed
//                scenarios pin the model with literal expectations before a
//                randomized phase. Latency figures follow IRQ_ARB_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

`ifdef IRQ_ARB_SYNC_EN
    localparam int LAT  = 4;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit SYNC = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [3:0] src_in    = '0;
    logic       cfg_we    = 1'b0;
    logic [1:0] cfg_addr  = '0;
    logic [3:0] cfg_wdata = '0;
    logic [3:0] cfg_rdata;
    logic       irq_req;
    logic [1:0] irq_id;
    logic       irq_ack   = 1'b0;
    logic       irq_done  = 1'b0;

    irq_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .src_in    (src_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: request flag, busy flag, presented id, registers
    // ------------------------------------------------------------------
    logic [3:0] m_pend = '0, m_en = '0, m_mode = '0;
    logic [3:0] m_prev = '0, m_s1 = '0, m_s2 = '0;
    logic       m_req  = 1'b0, m_busy = 1'b0;
    logic [1:0] m_id   = '0;
    logic [3:0] t_s, t_rise, t_act, t_low, t_en, t_mode, t_pend;

    always @(posedge clk) begin
        t_s = SYNC ? m_s2 : src_in;
        if (reset) begin
            m_pend = '0; m_en = '0; m_mode = '0;
            m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_req  = 1'b0; m_busy = 1'b0; m_id = '0;
        end else begin
            t_en   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : m_en;
            t_mode = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : m_mode;
            t_rise = t_s & ~m_prev;
            for (int i = 0; i < 4; i++) begin
                if (m_mode[i]) begin
                    t_pend[i] = t_s[i];
                end else begin
                    t_pend[i] = m_pend[i];
                    if (cfg_we && cfg_addr == 2'd1 && cfg_wdata[i]) t_pend[i] = 1'b0;
                    if (m_req && irq_ack && int'(m_id) == i)        t_pend[i] = 1'b0;
                    if (t_rise[i])                                  t_pend[i] = 1'b1;
                end
            end
            if (m_req) begin
                if (irq_ack) begin
                    m_req  = 1'b0;
                    m_busy = 1'b1;
                end else if (!t_en[m_id]) begin
                    m_req = 1'b0;
                end
            end else if (m_busy) begin
                if (irq_done) m_busy = 1'b0;
            end else begin
                t_act = m_pend & m_en;
                if (t_act != 4'd0) begin
                    t_low = t_act & (~t_act + 4'd1);   // isolate lowest set bit
                    m_id  = 2'($clog2(t_low));
                    m_req = 1'b1;
                end
            end
            m_pend = t_pend;
            m_en   = t_en;
            m_mode = t_mode;
            m_prev = t_s;
            m_s2   = m_s1;
            m_s1   = src_in;
        end
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    bit         cmp_en = 1'b0;
    logic [3:0] exp_rd;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_req", 32'(irq_req), 32'(m_req));
            if (m_req) chk("model_id", 32'(irq_id), 32'(m_id));
            case (cfg_addr)
                2'd0:    exp_rd = m_en;
                2'd1:    exp_rd = m_pend;
                2'd2:    exp_rd = m_mode;
                default: exp_rd = {2'b00, m_req, (m_req | m_busy)};
            endcase
            chk("model_rdata", 32'(cfg_rdata), 32'(exp_rd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [3:0] e);
        cfg_addr = a;
        #1;
        chk(name, 32'(cfg_rdata), 32'(e));
    endtask

    task automatic exp_req(input string name, input logic r, input logic [1:0] id);
        chk(name, 32'(irq_req), 32'(r));
        if (r) chk({name, "_id"}, 32'(irq_id), 32'(id));
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; cyc(1); irq_done = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        cyc(3);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        exp_req("rst_req", 1'b0, 2'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        rd("rst_en",   2'd0, 4'h0);
        rd("rst_pend", 2'd1, 4'h0);
        rd("rst_mode", 2'd2, 4'h0);

        // 1: single edge on source 2
        wr(2'd0, 4'hF);
        src_in[2] = 1'b1; cyc(1); src_in[2] = 1'b0;
        cyc(LAT - 2);
        exp_req("s1_early", 1'b0, 2'd0);
        cyc(1);
        exp_req("s1_req", 1'b1, 2'd2);
        rd("s1_status", 2'd3, 4'b0011);
        pulse_ack();
        exp_req("s1_ackdrop", 1'b0, 2'd0);
        rd("s1_pend", 2'd1, 4'h0);
        rd("s1_status_svc", 2'd3, 4'b0001);
        pulse_done();
        rd("s1_status_idle", 2'd3, 4'b0000);

        // 2: sources 1 and 3 rise together
        src_in = 4'b1010; cyc(1); src_in = 4'b0000;
        cyc(LAT - 1);
        exp_req("s2_first", 1'b1, 2'd1);
        pulse_ack();
        pulse_done();
        exp_req("s2_gap", 1'b0, 2'd0);
        cyc(1);
        exp_req("s2_second", 1'b1, 2'd3);
        pulse_ack();
        pulse_done();
        cyc(1);

        // 3: new edge on source 0 in its own ack cycle
        src_in[0] = 1'b1; cyc(1); src_in[0] = 1'b0;
        cyc(LAT - 1);
        exp_req("s3_req", 1'b1, 2'd0);
        if (!SYNC) begin
            src_in[0] = 1'b1; irq_ack = 1'b1;
            cyc(1);
            src_in[0] = 1'b0; irq_ack = 1'b0;
        end else begin
            src_in[0] = 1'b1; cyc(1); src_in[0] = 1'b0;
            cyc(1);
            irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        end
        rd("s3_pend", 2'd1, 4'b0001);
        pulse_done();
        exp_req("s3_idle", 1'b0, 2'd0);
        cyc(1);
        exp_req("s3_rereq", 1'b1, 2'd0);
        pulse_ack();
        rd("s3_pend_clr", 2'd1, 4'b0000);
        pulse_done();

        // 4: pending while disabled, then enable
        wr(2'd0, 4'h0);
        src_in[1] = 1'b1; cyc(1); src_in[1] = 1'b0;
        cyc(LAT + 1);
        exp_req("s4_noreq", 1'b0, 2'd0);
        rd("s4_pend", 2'd1, 4'b0010);
        wr(2'd0, 4'b0010);
        exp_req("s4_wait", 1'b0, 2'd0);
        cyc(1);
        exp_req("s4_req", 1'b1, 2'd1);

        // 5: withdraw by disabling in REQ
        wr(2'd0, 4'h0);
        exp_req("s5_withdraw", 1'b0, 2'd0);
        rd("s5_pend", 2'd1, 4'b0010);
        rd("s5_status", 2'd3, 4'b0000);
        wr(2'd1, 4'b0000);
        rd("s5_pend_w0", 2'd1, 4'b0010);
        wr(2'd1, 4'b0010);
        rd("s5_pend_w1c", 2'd1, 4'b0000);

        // 6: level mode on source 3, then reset in SERVICE
        wr(2'd0, 4'hF);
        wr(2'd2, 4'b1000);
        rd("s6_mode", 2'd2, 4'b1000);
        src_in[3] = 1'b1;
        cyc(LAT);
        exp_req("s6_req", 1'b1, 2'd3);
        pulse_ack();
        exp_req("s6_svc", 1'b0, 2'd0);
        rd("s6_pend_level", 2'd1, 4'b1000);
        pulse_done();
        cyc(1);
        exp_req("s6_rereq", 1'b1, 2'd3);
        pulse_ack();
        reset = 1'b1; src_in = 4'h0;
        cyc(1);
        reset = 1'b0;
        exp_req("s6_rst_req", 1'b0, 2'd0);
        chk("s6_rst_id", 32'(irq_id), 32'd0);
        rd("s6_rst_en",   2'd0, 4'h0);
        rd("s6_rst_pend", 2'd1, 4'h0);
        rd("s6_rst_mode", 2'd2, 4'h0);

        // Randomized phase, checked by the compare process
        wr(2'd0, 4'hF);
        for (int c = 0; c < 4000; c++) begin
            src_in    = 4'($urandom_range(0, 15));
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_done  = ($urandom_range(0, 3) == 0);
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 4'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        src_in = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0; reset = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_irq_arbiter
`default_nettype wire
